// File: rtl/cxl_wr_arbiter_pkg.sv
// Shared definitions for the CXL write-port arbiter: default AXI widths,
// FSM state encoding and a constant-width helper.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package cxl_wr_arbiter_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } arb_state_e;

  function automatic int clog2_f(input int value);
    int w;
    w = 0;
    while ((32'sd1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cxl_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// wrapping around NUM_REQ.
module rr_arbiter
  import cxl_wr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = clog2_f(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] cand_s;

  // Scan from the farthest offset down so the closest eligible index wins.
  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    cand_s    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand_s    = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      grant_idx = req[cand_s] ? cand_s : grant_idx;
      any_req   = any_req | req[cand_s];
    end
  end

endmodule

// File: rtl/cxl_wr_arbiter.sv
// Shares one single-beat AW/W/B write port among NUM_REQ requesters with
// round-robin grant, id tagging, B routing by bid and an outstanding-write cap.
module cxl_wr_arbiter
  import cxl_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = `AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH      = `AXI_DATA_WIDTH,
  parameter int ID_WIDTH        = `AXI_ID_WIDTH,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_awaddr_i,
  input  logic [NUM_REQ-1:0]           req_awvalid_i,
  output logic [NUM_REQ-1:0]           req_awready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NUM_REQ-1:0]           req_wvalid_i,
  output logic [NUM_REQ-1:0]           req_wready_o,
  output logic [NUM_REQ-1:0]           req_bvalid_o,
  input  logic [NUM_REQ-1:0]           req_bready_i,
  output logic [ID_WIDTH-1:0]          m_awid_o,
  output logic [ADDR_WIDTH-1:0]        m_awaddr_o,
  output logic                         m_awvalid_o,
  input  logic                         m_awready_i,
  output logic [ID_WIDTH-1:0]          m_wid_o,
  output logic [DATA_WIDTH-1:0]        m_wdata_o,
  output logic                         m_wvalid_o,
  input  logic                         m_wready_i,
  input  logic [ID_WIDTH-1:0]          m_bid_i,
  input  logic                         m_bvalid_i,
  output logic                         m_bready_o,
  output logic                         err_o
);

  localparam int IDX_W = clog2_f(NUM_REQ);
  localparam int CNT_W = clog2_f(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e       state_r, state_nx_s;
  logic [IDX_W-1:0] grant_r, grant_nx_s, rr_ptr_r, rr_ptr_nx_s, pick_s, bid_idx_s;
  logic             aw_done_r, aw_done_nx_s, w_done_r, w_done_nx_s;
  logic [CNT_W-1:0] out_cnt_r;
  logic             err_r;
  logic [NUM_REQ-1:0] elig_s;
  logic             any_req_s, aw_hs_s, w_hs_s, send_done_s;
  logic             bid_ok_s, b_hs_s, cnt_dec_s, b_err_s;

  assign elig_s = req_awvalid_i & req_wvalid_i;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (elig_s),
    .rr_ptr    (rr_ptr_r),
    .grant_idx (pick_s),
    .any_req   (any_req_s)
  );

  assign m_awaddr_o = req_awaddr_i[int'(grant_r) * ADDR_WIDTH +: ADDR_WIDTH];
  assign m_wdata_o  = req_wdata_i[int'(grant_r) * DATA_WIDTH +: DATA_WIDTH];
  assign m_awid_o   = ID_WIDTH'(grant_r);
  assign m_wid_o    = ID_WIDTH'(grant_r);

  // Downstream valids and the granted requester's readys exist only in S_SEND.
  always_comb begin
    m_awvalid_o   = 1'b0;
    m_wvalid_o    = 1'b0;
    req_awready_o = '0;
    req_wready_o  = '0;
    if (state_r == S_SEND) begin
      m_awvalid_o            = !aw_done_r;
      m_wvalid_o             = !w_done_r;
      req_awready_o[grant_r] = m_awready_i & !aw_done_r;
      req_wready_o[grant_r]  = m_wready_i & !w_done_r;
    end else begin
      m_awvalid_o = 1'b0;
      m_wvalid_o  = 1'b0;
    end
  end

  assign aw_hs_s     = m_awvalid_o & m_awready_i;
  assign w_hs_s      = m_wvalid_o & m_wready_i;
  assign send_done_s = (state_r == S_SEND) & (aw_done_r | aw_hs_s) & (w_done_r | w_hs_s);

  assign bid_ok_s  = ({1'b0, m_bid_i} < (ID_WIDTH + 1)'(NUM_REQ));
  assign bid_idx_s = m_bid_i[IDX_W-1:0];

  // Route B by bid; unknown ids are swallowed so the downstream never stalls.
  always_comb begin
    req_bvalid_o = '0;
    m_bready_o   = 1'b0;
    if (rst) begin
      req_bvalid_o = '0;
      m_bready_o   = 1'b0;
    end else if (bid_ok_s) begin
      req_bvalid_o[bid_idx_s] = m_bvalid_i;
      m_bready_o              = req_bready_i[bid_idx_s];
    end else begin
      m_bready_o = 1'b1;
    end
  end

  assign b_hs_s    = m_bvalid_i & m_bready_o;
  assign cnt_dec_s = b_hs_s & bid_ok_s & (out_cnt_r != '0);
  assign b_err_s   = b_hs_s & (!bid_ok_s | (out_cnt_r == '0));

  // Next-state: arbitrate in S_IDLE, hold grant until both beats are accepted.
  always_comb begin
    state_nx_s   = state_r;
    grant_nx_s   = grant_r;
    rr_ptr_nx_s  = rr_ptr_r;
    aw_done_nx_s = aw_done_r;
    w_done_nx_s  = w_done_r;
    case (state_r)
      S_IDLE: begin
        if (any_req_s && (out_cnt_r < CNT_MAX)) begin
          state_nx_s   = S_SEND;
          grant_nx_s   = pick_s;
          aw_done_nx_s = 1'b0;
          w_done_nx_s  = 1'b0;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_SEND: begin
        aw_done_nx_s = aw_done_r | aw_hs_s;
        w_done_nx_s  = w_done_r | w_hs_s;
        if (send_done_s) begin
          state_nx_s  = S_IDLE;
          rr_ptr_nx_s = (grant_r == LAST_IDX) ? '0 : grant_r + IDX_W'(1);
        end else begin
          state_nx_s = S_SEND;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // FSM and arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      grant_r   <= '0;
      rr_ptr_r  <= '0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      grant_r   <= grant_nx_s;
      rr_ptr_r  <= rr_ptr_nx_s;
      aw_done_r <= aw_done_nx_s;
      w_done_r  <= w_done_nx_s;
    end
  end

  // Outstanding-write counter; simultaneous issue and retire cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt_r <= '0;
    end else if (send_done_s && !cnt_dec_s) begin
      out_cnt_r <= out_cnt_r + CNT_W'(1);
    end else if (cnt_dec_s && !send_done_s) begin
      out_cnt_r <= out_cnt_r - CNT_W'(1);
    end else begin
      out_cnt_r <= out_cnt_r;
    end
  end

  // Sticky error for stray or unexpected B responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (b_err_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_o = err_r;

endmodule

// File: tb/tb_cxl_wr_arbiter.sv
// Directed bench for cxl_wr_arbiter (NUM_REQ=2, MAX_OUTSTANDING=4).
module tb_cxl_wr_arbiter;

  logic        clk, rst;
  logic [63:0] req_awaddr, req_wdata;
  logic [1:0]  req_awvalid, req_wvalid, req_awready, req_wready, req_bvalid, req_bready;
  logic [3:0]  m_awid, m_wid, m_bid;
  logic [31:0] m_awaddr, m_wdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready, err;

  int total_cnt = 0;
  int fail_cnt  = 0;

  cxl_wr_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_awaddr_i(req_awaddr), .req_awvalid_i(req_awvalid), .req_awready_o(req_awready),
    .req_wdata_i(req_wdata), .req_wvalid_i(req_wvalid), .req_wready_o(req_wready),
    .req_bvalid_o(req_bvalid), .req_bready_i(req_bready),
    .m_awid_o(m_awid), .m_awaddr_o(m_awaddr), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
    .m_wid_o(m_wid), .m_wdata_o(m_wdata), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
    .m_bid_i(m_bid), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready), .err_o(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_awaddr = {32'h0000_3000, 32'h0000_1000};
    req_wdata  = {32'h0000_00C3, 32'h0000_00A5};
    req_awvalid = 2'b00; req_wvalid = 2'b00; req_bready = 2'b00;
    m_awready = 1'b0; m_wready = 1'b0; m_bid = 4'd0; m_bvalid = 1'b0;
    #2;
    chk("rst_awvalid", 64'(m_awvalid), 64'd0);
    chk("rst_wvalid",  64'(m_wvalid),  64'd0);
    chk("rst_err",     64'(err),       64'd0);
    step();
    rst = 1'b0;

    // Single write from requester 0
    req_awvalid = 2'b01; req_wvalid = 2'b01; m_awready = 1'b1; m_wready = 1'b1;
    #1;
    chk("idle_no_awvalid", 64'(m_awvalid), 64'd0);
    step();
    chk("single_awvalid", 64'(m_awvalid), 64'd1);
    chk("single_awid",    64'(m_awid),    64'd0);
    chk("single_awaddr",  64'(m_awaddr),  64'h1000);
    chk("single_wdata",   64'(m_wdata),   64'hA5);
    chk("single_awready", 64'(req_awready), 64'b01);
    chk("single_wready",  64'(req_wready),  64'b01);
    step();
    req_awvalid = 2'b00; req_wvalid = 2'b00;
    m_bid = 4'd0; m_bvalid = 1'b1; req_bready = 2'b01;
    #1;
    chk("single_back_idle", 64'(m_awvalid), 64'd0);
    chk("single_cnt1",      64'(dut.out_cnt_r), 64'd1);
    chk("single_bvalid",    64'(req_bvalid), 64'b01);
    chk("single_bready",    64'(m_bready),   64'd1);
    step();
    m_bvalid = 1'b0;
    #1;
    chk("single_cnt0", 64'(dut.out_cnt_r), 64'd0);

    // Fairness: both requesters held; rr_ptr is 1 after the write above
    req_awvalid = 2'b11; req_wvalid = 2'b11;
    #1;
    step();
    chk("rr_g1_id",    64'(m_awid), 64'd1);
    chk("rr_g1_ready", 64'(req_awready), 64'b10);
    chk("rr_g1_addr",  64'(m_awaddr), 64'h3000);
    step();
    chk("rr_gap", 64'(m_awvalid), 64'd0);
    step();
    chk("rr_g2_id",    64'(m_awid), 64'd0);
    chk("rr_g2_ready", 64'(req_awready), 64'b01);
    step();
    step();
    chk("rr_g3_id", 64'(m_awid), 64'd1);
    step();
    step();
    chk("rr_g4_id", 64'(m_awid), 64'd0);
    step();
    chk("credit_cnt4", 64'(dut.out_cnt_r), 64'd4);

    // Credit limit: fifth write stalls until a B returns
    step();
    chk("credit_stall_awvalid", 64'(m_awvalid), 64'd0);
    chk("credit_stall_ready",   64'(req_awready | req_wready), 64'd0);
    m_bid = 4'd1; m_bvalid = 1'b1; req_bready = 2'b11;
    #1;
    chk("credit_b1_route", 64'(req_bvalid), 64'b10);
    step();
    m_bvalid = 1'b0;
    #1;
    chk("credit_same_cycle_stall", 64'(m_awvalid), 64'd0);
    chk("credit_cnt3", 64'(dut.out_cnt_r), 64'd3);
    step();
    chk("credit_issue", 64'(m_awvalid), 64'd1);
    chk("credit_issue_id", 64'(m_awid), 64'd1);
    m_bid = 4'd0; m_bvalid = 1'b1;
    #1;
    step();
    m_bvalid = 1'b0; req_awvalid = 2'b00; req_wvalid = 2'b00;
    #1;
    chk("credit_inc_dec_cnt", 64'(dut.out_cnt_r), 64'd3);

    // Split handshake: AW accepted first, W three cycles later
    req_awaddr = {32'h0000_3000, 32'h0000_2000};
    req_wdata  = {32'h0000_00C3, 32'h0000_005A};
    req_awvalid = 2'b11; req_wvalid = 2'b11; m_awready = 1'b1; m_wready = 1'b0;
    #1;
    step();
    chk("split_c1_aw",     64'(m_awvalid), 64'd1);
    chk("split_c1_w",      64'(m_wvalid),  64'd1);
    chk("split_c1_awrdy",  64'(req_awready), 64'b01);
    chk("split_c1_wrdy",   64'(req_wready),  64'b00);
    step();
    req_awvalid = 2'b10;
    #1;
    chk("split_c2_aw",    64'(m_awvalid), 64'd0);
    chk("split_c2_w",     64'(m_wvalid),  64'd1);
    chk("split_c2_wid",   64'(m_wid),     64'd0);
    chk("split_c2_wdata", 64'(m_wdata),   64'h5A);
    chk("split_c2_rdy",   64'(req_awready | req_wready), 64'd0);
    step();
    chk("split_c3_w", 64'(m_wvalid), 64'd1);
    step();
    m_wready = 1'b1;
    #1;
    chk("split_c4_wrdy",  64'(req_wready),  64'b01);
    chk("split_c4_awrdy", 64'(req_awready), 64'b00);
    step();
    req_wvalid = 2'b10;
    #1;
    chk("split_done_w", 64'(m_wvalid), 64'd0);
    chk("split_cnt4",   64'(dut.out_cnt_r), 64'd4);
    step();
    chk("split_full_stall", 64'(m_awvalid), 64'd0);

    // Bad id and backpressured B
    m_bid = 4'd3; m_bvalid = 1'b1; req_bready = 2'b00;
    #1;
    chk("badid_bready", 64'(m_bready),   64'd1);
    chk("badid_bvalid", 64'(req_bvalid), 64'b00);
    chk("badid_err_pre", 64'(err), 64'd0);
    step();
    chk("badid_err", 64'(err), 64'd1);
    m_bid = 4'd1; req_bready = 2'b01;
    #1;
    chk("bp_bready",  64'(m_bready),   64'd0);
    chk("bp_bvalid",  64'(req_bvalid), 64'b10);
    step();
    chk("bp_cnt4", 64'(dut.out_cnt_r), 64'd4);
    m_bid = 4'd0; req_bready = 2'b11;
    #1;
    step();
    m_bvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    #1;
    chk("b0_cnt3", 64'(dut.out_cnt_r), 64'd3);
    chk("err_sticky", 64'(err), 64'd1);

    // Reset in S_SEND
    step();
    chk("rst_send_aw", 64'(m_awvalid), 64'd1);
    chk("rst_send_id", 64'(m_awid), 64'd1);
    m_awready = 1'b1; m_wready = 1'b1; m_bid = 4'd0; m_bvalid = 1'b1;
    #1;
    chk("rst_send_awrdy", 64'(req_awready), 64'b10);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_aw",     64'(m_awvalid), 64'd0);
    chk("rst_mid_w",      64'(m_wvalid),  64'd0);
    chk("rst_mid_readys", 64'(req_awready | req_wready), 64'd0);
    chk("rst_mid_bready", 64'(m_bready), 64'd0);
    chk("rst_mid_bvalid", 64'(req_bvalid), 64'd0);
    chk("rst_mid_cnt",    64'(dut.out_cnt_r), 64'd0);
    chk("rst_mid_ptr",    64'(dut.rr_ptr_r), 64'd0);
    chk("rst_mid_err",    64'(err), 64'd0);
    step();
    rst = 1'b0; m_bvalid = 1'b0;
    req_awvalid = 2'b11; req_wvalid = 2'b11;
    #1;
    step();
    chk("post_rst_grant0", 64'(m_awid), 64'd0);
    chk("post_rst_aw",     64'(m_awvalid), 64'd1);
    req_awvalid = 2'b00; req_wvalid = 2'b00;
    step();

    $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
    $finish;
  end

endmodule
